key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Key conditioner for the two stopwatch buttons (bit0 start, bit1 lap).
// Synchronizes and debounces each raw switch, then turns the debounced level
// into press / release / long-press pulses. Every output is a flop.
// The two keys share only the sample-rate counter.
module key_conditioner #(
  parameter logic [19:0] SAMPLE_DIV   = 20'd100_000,
  parameter int unsigned DEB_LEN      = 5,
  parameter int unsigned LONG_SAMPLES = 200
) (
  input  logic       clk0,
  input  logic       reset_sw,
  input  logic [1:0] key_in,
  output logic       sample_tick,
  output logic [1:0] key_level,
  output logic [1:0] press_pulse,
  output logic [1:0] release_pulse,
  output logic [1:0] long_pulse
);

  localparam int unsigned NKEY   = 2;
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned HOLD_W = (LONG_SAMPLES > 255) ? $clog2(LONG_SAMPLES + 1) : 8;

  localparam logic [CNT_W-1:0]  CNT_LAST  = SAMPLE_DIV - CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  logic [NKEY-1:0]  r_sync1;
  logic [NKEY-1:0]  r_sync2;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;
  logic             r_tick_d;

  // Two-flop synchronizer on the raw switch inputs
  always_ff @(posedge clk0 or posedge reset_sw) begin
    if (reset_sw) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Next value of the shared sample-rate counter (0..SAMPLE_DIV-1, wrapping)
  always_comb begin
    w_cnt_nxt = r_sample_cnt + CNT_W'(1);
    if (r_sample_cnt == CNT_LAST) begin
      w_cnt_nxt = '0;
    end
  end

  // Sample counter plus the registered strobe; r_tick is high exactly while
  // the counter sits at its last value. r_tick_d lines the strobe up with the
  // cycle in which the debounce window already holds the new sample.
  always_ff @(posedge clk0 or posedge reset_sw) begin
    if (reset_sw) begin
      r_sample_cnt <= '0;
      r_tick       <= 1'b0;
      r_tick_d     <= 1'b0;
    end else begin
      r_sample_cnt <= w_cnt_nxt;
      r_tick       <= (w_cnt_nxt == CNT_LAST);
      r_tick_d     <= r_tick;
    end
  end

  assign sample_tick = r_tick;

  for (genvar k = 0; k < NKEY; k++) begin : g_key
    logic [DEB_LEN-1:0] r_shift;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic               r_long;
    logic               w_all_one;
    logic               w_all_zero;
    logic               w_rise;
    logic               w_fall;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               w_long_nxt;

    // Debounce window: shift in one synchronized sample per tick
    always_ff @(posedge clk0 or posedge reset_sw) begin
      if (reset_sw) begin
        r_shift <= '0;
      end else if (r_tick) begin
        r_shift <= DEB_LEN'({r_shift, r_sync2[k]});
      end
    end

    // A full window of equal samples that disagrees with the level is an edge
    always_comb begin
      w_all_one  = &r_shift;
      w_all_zero = ~|r_shift;
      w_rise     = w_all_one & ~r_level;
      w_fall     = w_all_zero & r_level;
    end

    // Debounced level with its press / release pulses, updated on the same edge
    always_ff @(posedge clk0 or posedge reset_sw) begin
      if (reset_sw) begin
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_rise;
        r_release <= w_fall;
        if (w_rise) begin
          r_level <= 1'b1;
        end else if (w_fall) begin
          r_level <= 1'b0;
        end
      end
    end

    // Hold-tracking FSM state, hold counter and long-press pulse registers
    always_ff @(posedge clk0 or posedge reset_sw) begin
      if (reset_sw) begin
        r_state <= ST_IDLE;
        r_hold  <= '0;
        r_long  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
        r_long  <= w_long_nxt;
      end
    end

    // Hold FSM: a release always takes priority over reaching the long threshold
    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_long_nxt  = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_HELD;
            w_hold_nxt  = '0;
          end
        end
        ST_HELD: begin
          if (w_fall) begin
            w_state_nxt = ST_IDLE;
          end else if (r_tick_d) begin
            w_hold_nxt = r_hold + HOLD_W'(1);
            if (r_hold == HOLD_LAST) begin
              w_state_nxt = ST_LONG;
              w_long_nxt  = 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (w_fall) begin
            w_state_nxt = ST_IDLE;
          end else if (r_tick_d && (r_hold != '1)) begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    assign key_level[k]     = r_level;
    assign press_pulse[k]   = r_press;
    assign release_pulse[k] = r_release;
    assign long_pulse[k]    = r_long;
  end

endmodule
